// File: rtl/channel.sv
// Single-entry 4-phase bundled-data channel: one sender handshake in, one receiver handshake out.
// Ports: clk, rst (async, active high), s_req/s_data/s_ack (sender), r_req/r_data/r_ack (receiver),
//   status (00 IDLE, 01 SEND_PEND, 10 BUSY), xfer_count (only with CHANNEL_XFER_COUNT_EN).
module channel #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic [1:0]       status
`ifdef CHANNEL_XFER_COUNT_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PEND = 2'b01;
  localparam logic [1:0] ST_BUSY = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } send_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RTZ
  } recv_state_e;

  send_state_e send_q, send_d;
  recv_state_e recv_q, recv_d;

  logic             full_q, full_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  logic capture;
  logic drain;

  // Send side: capture only into an empty buffer, judged by the
  // registered full flag, so a drain and a capture never share an edge.
  always_comb begin
    send_d  = send_q;
    capture = 1'b0;
    unique case (send_q)
      S_IDLE: begin
        if (s_req && !full_q) begin
          capture = 1'b1;
          send_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (!s_req) begin
          send_d = S_IDLE;
        end
      end
    endcase
  end

  // Receive side: full is released on the edge that sees r_ack high.
  always_comb begin
    recv_d = recv_q;
    drain  = 1'b0;
    unique case (recv_q)
      R_IDLE: begin
        if (full_q) begin
          recv_d = R_REQ;
        end
      end
      R_REQ: begin
        if (r_ack) begin
          drain  = 1'b1;
          recv_d = R_RTZ;
        end
      end
      R_RTZ: begin
        if (!r_ack) begin
          recv_d = R_IDLE;
        end
      end
      default: begin
        recv_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (capture) begin
      buf_d  = s_data;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_q <= S_IDLE;
      recv_q <= R_IDLE;
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      send_q <= send_d;
      recv_q <= recv_d;
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

  assign s_ack  = (send_q == S_ACK);
  assign r_req  = (recv_q == R_REQ);
  assign r_data = buf_q;

  always_comb begin
    status = ST_IDLE;
    if (full_q || (send_q != S_IDLE) || (recv_q != R_IDLE)) begin
      status = ST_BUSY;
    end else if (s_req) begin
      status = ST_PEND;
    end
  end

`ifdef CHANNEL_XFER_COUNT_EN
  logic [31:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (drain) begin
      xfer_count_d = xfer_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_channel.sv
// Self-checking bench for channel: directed handshake/timing steps,
// then a randomized 100-word stream checked against an ordered queue.
module tb_channel;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         s_req;
  logic [W-1:0] s_data;
  logic         s_ack;
  logic         r_req;
  logic [W-1:0] r_data;
  logic         r_ack;
  logic [1:0]   status;
`ifdef CHANNEL_XFER_COUNT_EN
  logic [31:0]  xfer_count;
`endif

  int checks   = 0;
  int failures = 0;

  channel #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_req     (s_req),
    .s_data    (s_data),
    .s_ack     (s_ack),
    .r_req     (r_req),
    .r_data    (r_data),
    .r_ack     (r_ack),
    .status    (status)
`ifdef CHANNEL_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sigs(input string tag, input logic sa,
                          input logic rr, input logic [1:0] st);
    chk({tag, "_s_ack"}, 64'(s_ack), 64'(sa));
    chk({tag, "_r_req"}, 64'(r_req), 64'(rr));
    chk({tag, "_status"}, 64'(status), 64'(st));
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] exp_w;
  int sent;
  int rcvd;
  int s_ph;
  int s_dly;
  int r_ph;
  int r_dly;
  int cyc;

  initial begin
    rst    = 1'b1;
    s_req  = 1'b0;
    s_data = '0;
    r_ack  = 1'b0;
    #2;
    chk_sigs("reset", 1'b0, 1'b0, 2'b00);
    chk("reset_r_data", r_data, 64'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_sigs("post_reset", 1'b0, 1'b0, 2'b00);

    // Single transfer
    w_a    = 64'h0000_0000_0011_1111_1111;
    s_data = w_a;
    s_req  = 1'b1;
    #1;
    chk("single_pend", 64'(status), 64'(2'b01));
    step();
    chk_sigs("single_e1", 1'b1, 1'b0, 2'b10);
    s_req = 1'b0;
    s_data = '1;
    step();
    chk_sigs("single_e2", 1'b0, 1'b1, 2'b10);
    chk("single_r_data", r_data, w_a);
    r_ack = 1'b1;
    step();
    chk_sigs("single_rtz", 1'b0, 1'b0, 2'b10);
    r_ack = 1'b0;
    step();
    chk_sigs("single_done", 1'b0, 1'b0, 2'b00);
    chk("single_hold", r_data, w_a);

    // Back-pressure
    w_a    = 64'hA5A5_0101_C3C3_7E7E;
    w_b    = 64'h1234_5678_9ABC_DEF0;
    s_data = w_a;
    s_req  = 1'b1;
    step();
    s_req = 1'b0;
    step();
    chk("bp_first_r_req", 64'(r_req), 64'h1);
    s_data = w_b;
    s_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_sigs("bp_hold", 1'b0, 1'b1, 2'b10);
      chk("bp_hold_data", r_data, w_a);
    end
    r_ack = 1'b1;
    step();
    chk_sigs("bp_drain_edge", 1'b0, 1'b0, 2'b10);
    r_ack = 1'b0;
    step();
    chk_sigs("bp_capture", 1'b1, 1'b0, 2'b10);
    s_req = 1'b0;
    step();
    chk_sigs("bp_second", 1'b0, 1'b1, 2'b10);
    chk("bp_second_data", r_data, w_b);
    r_ack = 1'b1;
    step();
    r_ack = 1'b0;
    step();
    chk_sigs("bp_done", 1'b0, 1'b0, 2'b00);
`ifdef CHANNEL_XFER_COUNT_EN
    chk("xfer_count_3", 64'(xfer_count), 64'd3);
`endif

    // Reset while in R_REQ
    s_data = 64'hDEAD_BEEF;
    s_req  = 1'b1;
    step();
    s_req = 1'b0;
    step();
    chk("rst_pre_r_req", 64'(r_req), 64'h1);
    chk("rst_pre_data", r_data, 64'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    chk_sigs("rst_mid", 1'b0, 1'b0, 2'b00);
    chk("rst_mid_data", r_data, 64'h0);
`ifdef CHANNEL_XFER_COUNT_EN
    chk("rst_mid_count", 64'(xfer_count), 64'd0);
`endif
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_sigs("rst_no_stale", 1'b0, 1'b0, 2'b00);
    end

    // Random stream
    sent  = 0;
    rcvd  = 0;
    s_ph  = 0;
    s_dly = int'($urandom_range(3));
    r_ph  = 0;
    r_dly = 0;
    cyc   = 0;
    while ((rcvd < 100) && (cyc < 10000)) begin
      case (s_ph)
        0: begin
          if (sent < 100) begin
            if (s_dly == 0) begin
              s_data = {$urandom, $urandom};
              exp_q.push_back(s_data);
              s_req = 1'b1;
              s_ph  = 1;
            end else begin
              s_dly--;
            end
          end
        end
        1: begin
          if (s_ack) begin
            s_req = 1'b0;
            s_ph  = 2;
          end
        end
        default: begin
          if (!s_ack) begin
            sent++;
            s_dly = int'($urandom_range(3));
            s_ph  = 0;
          end
        end
      endcase
      case (r_ph)
        0: begin
          if (r_req) begin
            r_dly = int'($urandom_range(3));
            r_ph  = 1;
          end
        end
        1: begin
          if (r_dly == 0) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("stream_data", r_data, exp_w);
            r_ack = 1'b1;
            r_ph  = 2;
          end else begin
            r_dly--;
          end
        end
        default: begin
          r_ack = 1'b0;
          rcvd++;
          r_ph  = 0;
        end
      endcase
      step();
      cyc++;
      chk("stream_status", 64'(status == 2'b11), 64'h0);
    end
    r_ack = 1'b0;
    s_req = 1'b0;
    step();
    step();
    chk("stream_received", 64'(rcvd), 64'd100);
    chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    chk_sigs("stream_end", 1'b0, 1'b0, 2'b00);
`ifdef CHANNEL_XFER_COUNT_EN
    chk("xfer_count_100", 64'(xfer_count), 64'd100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
